native_mem_slave: RTL and testbench

Parametrised, synthesisable memory slave for the picorv32 native memory interface. It replaces the ad-hoc one-cycle memory model in CPU benches and adds four things: configurable depth and base address, fixed or pseudo-random wait states, a riscv-tests style `tohost` pass/fail mailbox, and sticky bus-error capture. It also provides per-type access counters. It sits directly on the core's `mem_*` port in simulation and FPGA smoke tests.

---
 rtl/native_mem_slave.sv | 215 +++++++++++++++++++++
 tb/tb_native_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_slave.sv
// Word-organised memory slave for the picorv32 native bus with wait-state
// insertion, a tohost pass/fail mailbox, first-error capture and access counters.
module native_mem_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned WAIT_MODE   = 0,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000,
   parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        test_done,
   output logic        test_pass,
   output logic [30:0] test_code,
   output logic        bus_error,
   output logic [31:0] err_addr,
   output logic [31:0] fetch_cnt,
   output logic [31:0] load_cnt,
   output logic [31:0] store_cnt,
   output logic [1:0]  o_dbg_state
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

   // Handshake: a request is taken in IDLE while mem_valid=1 and no response is
   // showing; mem_valid must then stay high until the single mem_ready cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_instr;
   logic [3:0]  r_cnt;
   logic [15:0] r_lfsr;
   logic        r_ready;
   logic [31:0] r_rdata;
   logic        r_done;
   logic        r_pass;
   logic [30:0] r_code;
   logic [31:0] r_mbox;
   logic        r_err;
   logic [31:0] r_err_addr;
   logic [31:0] r_fetch;
   logic [31:0] r_load;
   logic [31:0] r_store;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept;
   logic        w_abort;
   logic        w_complete;
   logic [3:0]  w_wait_load;
   logic        w_lfsr_fb;
   logic [32:0] w_off;
   logic        w_in_range;
   logic        w_is_mbox;
   logic        w_is_write;
   logic        w_error;
   logic [AW-1:0] w_idx;
   logic [31:0] w_read_data;

   assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_wait_load = (WAIT_MODE == 1) ? 4'(32'(r_lfsr[3:0]) % (WAIT_CYCLES + 1))
                                         : 4'(WAIT_CYCLES);

   // A 33-bit offset lets addresses below BASE_ADDR wrap high and fail the span test.
   assign w_off      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
   assign w_in_range = (w_off < SPAN) && (r_addr[1:0] == 2'b00);
   assign w_idx      = w_off[AW+1:2];
   assign w_is_mbox  = (r_addr == TOHOST_ADDR);
   assign w_is_write = (r_wstrb != 4'h0);
   assign w_error    = !w_in_range &&
                       !(w_is_mbox && (!w_is_write || (r_wstrb == 4'hF)));

   always_comb begin
      w_read_data = ERR_RDATA;
      if (w_in_range)
         w_read_data = r_mem[w_idx];
      else if (!w_error)
         w_read_data = r_mbox;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_abort    = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_valid && !r_ready) begin
               w_accept = 1'b1;
               w_next   = (w_wait_load != 4'd0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (!mem_valid) begin
               w_abort = 1'b1;
               w_next  = S_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            w_complete = 1'b1;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_wstrb    <= 4'd0;
         r_instr    <= 1'b0;
         r_cnt      <= 4'd0;
         r_lfsr     <= LFSR_SEED;
         r_ready    <= 1'b0;
         r_rdata    <= 32'd0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_code     <= 31'd0;
         r_mbox     <= 32'd0;
         r_err      <= 1'b0;
         r_err_addr <= 32'd0;
         r_fetch    <= 32'd0;
         r_load     <= 32'd0;
         r_store    <= 32'd0;
      end else begin
         r_state <= w_next;
         r_ready <= w_complete;

         if (w_accept) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_cnt   <= w_wait_load;
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_complete) begin
            r_rdata <= w_read_data;
            if (r_instr) begin
               if (r_fetch != 32'hFFFF_FFFF) r_fetch <= r_fetch + 32'd1;
            end else if (w_is_write) begin
               if (r_store != 32'hFFFF_FFFF) r_store <= r_store + 32'd1;
            end else begin
               if (r_load != 32'hFFFF_FFFF) r_load <= r_load + 32'd1;
            end

            // Only the first nonzero mailbox write is taken; everything after is dropped.
            if (w_error) begin
               if (!r_err) begin
                  r_err      <= 1'b1;
                  r_err_addr <= r_addr;
               end
            end else if (w_is_mbox && w_is_write && !r_done && (r_wdata != 32'd0)) begin
               r_mbox <= r_wdata;
               r_done <= 1'b1;
               r_pass <= (r_wdata == 32'd1);
               r_code <= r_wdata[31:1];
            end
         end

         if (w_abort && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
         end
      end
   end

   // Memory has no reset so its contents survive resetn; a write lands only on a
   // RESP edge that is not itself a reset edge.
   always @(posedge clk) begin
      if (resetn && w_complete && w_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign mem_ready   = r_ready;
   assign mem_rdata   = r_rdata;
   assign test_done   = r_done;
   assign test_pass   = r_pass;
   assign test_code   = r_code;
   assign bus_error   = r_err;
   assign err_addr    = r_err_addr;
   assign fetch_cnt   = r_fetch;
   assign load_cnt    = r_load;
   assign store_cnt   = r_store;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_native_mem_slave.sv
// Bench for native_mem_slave: a fixed-wait instance (3 waits) and a random-wait
// instance (up to 7 waits) driven by random bus traffic against a reference model.
module tb_native_mem_slave;

   localparam logic [31:0] TOHOST = 32'h1000_0000;
   localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn  [2];
   logic        valid [2];
   logic        instr [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  wstrb [2];
   logic        ready [2];
   logic [31:0] rdata [2];
   logic        done  [2];
   logic        pass  [2];
   logic [30:0] code  [2];
   logic        berr  [2];
   logic [31:0] eaddr [2];
   logic [31:0] fcnt  [2];
   logic [31:0] lcnt  [2];
   logic [31:0] scnt  [2];
   logic [1:0]  dbg   [2];

   native_mem_slave #(.WAIT_CYCLES(3), .WAIT_MODE(0)) u_fix (
      .clk(clk), .resetn(rstn[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
      .mem_ready(ready[0]), .mem_rdata(rdata[0]), .test_done(done[0]),
      .test_pass(pass[0]), .test_code(code[0]), .bus_error(berr[0]),
      .err_addr(eaddr[0]), .fetch_cnt(fcnt[0]), .load_cnt(lcnt[0]),
      .store_cnt(scnt[0]), .o_dbg_state(dbg[0])
   );

   native_mem_slave #(.WAIT_CYCLES(7), .WAIT_MODE(1)) u_rnd (
      .clk(clk), .resetn(rstn[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
      .mem_ready(ready[1]), .mem_rdata(rdata[1]), .test_done(done[1]),
      .test_pass(pass[1]), .test_code(code[1]), .bus_error(berr[1]),
      .err_addr(eaddr[1]), .fetch_cnt(fcnt[1]), .load_cnt(lcnt[1]),
      .store_cnt(scnt[1]), .o_dbg_state(dbg[1])
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [2][1024];
   logic [31:0] m_mbox [2];
   logic        m_done [2];
   logic        m_pass [2];
   logic [30:0] m_code [2];
   logic        m_err  [2];
   logic [31:0] m_eaddr [2];
   logic [31:0] m_fetch [2];
   logic [31:0] m_load  [2];
   logic [31:0] m_store [2];

   function automatic void model_reset(input int d);
      m_mbox[d] = 32'd0; m_done[d] = 1'b0; m_pass[d] = 1'b0; m_code[d] = 31'd0;
      m_err[d] = 1'b0; m_eaddr[d] = 32'd0;
      m_fetch[d] = 32'd0; m_load[d] = 32'd0; m_store[d] = 32'd0;
   endfunction

   function automatic logic [31:0] model_access(input int d, input logic [31:0] a,
         input logic [31:0] wd, input logic [3:0] ws, input logic ins);
      logic [31:0] rd;
      bit in_rng, mbox, err;
      in_rng = (a < 32'd4096) && (a % 4 == 0);
      mbox   = (a == TOHOST);
      err    = !in_rng && !(mbox && (ws == 4'h0 || ws == 4'hF));
      if (err)         rd = ERRD;
      else if (in_rng) rd = m_mem[d][a / 4];
      else             rd = m_mbox[d];
      if (err) begin
         if (!m_err[d]) begin
            m_err[d] = 1'b1;
            m_eaddr[d] = a;
         end
      end else if (ws != 4'h0) begin
         if (in_rng) begin
            for (int b = 0; b < 4; b++)
               if (ws[b]) m_mem[d][a / 4][8*b +: 8] = wd[8*b +: 8];
         end else if (!m_done[d] && wd != 32'd0) begin
            m_mbox[d] = wd;
            m_done[d] = 1'b1;
            m_pass[d] = (wd == 32'd1);
            m_code[d] = 31'(wd / 2);
         end
      end
      if (ins)               m_fetch[d] = m_fetch[d] + 1;
      else if (ws != 4'h0)   m_store[d] = m_store[d] + 1;
      else                   m_load[d]  = m_load[d] + 1;
      return rd;
   endfunction

   // ---------------- scoreboard monitor ----------------
   logic [32:0] exp_q0 [$];
   logic [32:0] exp_q1 [$];
   logic [32:0] e0, e1;

   always @(negedge clk) begin
      if (ready[0]) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ready0: got ready=1, required no response");
         end else begin
            e0 = exp_q0.pop_front();
            if (e0[32]) chk("rdata0", rdata[0], e0[31:0]);
         end
      end
      if (ready[1]) begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ready1: got ready=1, required no response");
         end else begin
            e1 = exp_q1.pop_front();
            if (e1[32]) chk("rdata1", rdata[1], e1[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   bit seen_lat [16];

   task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
         input logic [3:0] ws, input logic ins, output logic [31:0] rd);
      logic [31:0] e;
      int cyc, lat;
      e = model_access(d, a, wd, ws, ins);
      if (d == 0) exp_q0.push_back({(ws == 4'h0), e});
      else        exp_q1.push_back({(ws == 4'h0), e});
      @(posedge clk); #1;
      addr[d] = a; wdata[d] = wd; wstrb[d] = ws; instr[d] = ins; valid[d] = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!ready[d] && cyc < 40);
      chk("ready_seen", 32'(ready[d]), 32'd1);
      rd = rdata[d];
      valid[d] = 1'b0; wstrb[d] = 4'h0; instr[d] = 1'b0;
      lat = cyc - 1;
      if (d == 0) begin
         chk("lat_fixed", 32'(lat), 32'd4);
      end else begin
         chk("lat_range", 32'(lat >= 1 && lat <= 8), 32'd1);
         if (lat >= 0 && lat < 16) seen_lat[lat] = 1'b1;
      end
   endtask

   task automatic do_reset(input int d);
      @(posedge clk); #1;
      rstn[d] = 1'b0; valid[d] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn[d] = 1'b1;
      model_reset(d);
   endtask

   task automatic check_state(input int d);
      chk("test_done", 32'(done[d]), 32'(m_done[d]));
      chk("test_pass", 32'(pass[d]), 32'(m_pass[d]));
      chk("test_code", 32'(code[d]), 32'(m_code[d]));
      chk("bus_error", 32'(berr[d]), 32'(m_err[d]));
      chk("err_addr", eaddr[d], m_eaddr[d]);
      chk("fetch_cnt", fcnt[d], m_fetch[d]);
      chk("load_cnt", lcnt[d], m_load[d]);
      chk("store_cnt", scnt[d], m_store[d]);
   endtask

   task automatic check_reset(input int d);
      chk("rst_ready", 32'(ready[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      check_state(d);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd, v, old_w10;
   int nseen;

   initial begin
      for (int d = 0; d < 2; d++) begin
         rstn[d] = 1'b0; valid[d] = 1'b0; instr[d] = 1'b0;
         addr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'h0;
         model_reset(d);
      end
      do_reset(0);
      do_reset(1);
      check_reset(0);
      check_reset(1);

      // fixed-wait instance: basic read with latency 4
      access(0, 32'h8, 32'h1234_5678, 4'hF, 1'b0, rd);
      access(0, 32'h8, 32'h0, 4'h0, 1'b0, rd);
      chk("word2_read", rd, 32'h1234_5678);

      // byte-lane merge
      access(0, 32'h14, 32'h0, 4'hF, 1'b0, rd);
      access(0, 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
      access(0, 32'h14, 32'h0, 4'h0, 1'b0, rd);
      chk("strobe_merge", rd, 32'h00BB_00DD);
      check_state(0);

      // random traffic on words 0..31
      for (int i = 0; i < 32; i++) access(0, 32'(i * 4), $urandom, 4'hF, 1'b0, rd);
      for (int i = 0; i < 80; i++) begin
         v = 32'($urandom_range(0, 31) * 4);
         case ($urandom_range(0, 3))
            0: access(0, v, 32'h0, 4'h0, 1'b0, rd);
            1: access(0, v, 32'h0, 4'h0, 1'b1, rd);
            2: access(0, v, $urandom, 4'hF, 1'b0, rd);
            default: access(0, v, $urandom, 4'($urandom_range(1, 15)), 1'b0, rd);
         endcase
      end
      check_state(0);

      // errors: out of range, misaligned, dropped misaligned write
      access(0, 32'h4000, 32'h0, 4'h0, 1'b0, rd);
      chk("err_rdata", rd, ERRD);
      chk("err_addr_first", eaddr[0], 32'h4000);
      access(0, 32'h6, 32'h0, 4'h0, 1'b0, rd);
      access(0, 32'h5, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
      access(0, 32'h4, 32'h0, 4'h0, 1'b0, rd);
      chk("err_addr_kept", eaddr[0], 32'h4000);
      check_state(0);

      // mailbox
      access(0, TOHOST, 32'h7, 4'h3, 1'b0, rd);
      access(0, TOHOST, 32'h0, 4'hF, 1'b0, rd);
      access(0, TOHOST, 32'h0, 4'h0, 1'b0, rd);
      chk("mbox_idle", 32'(done[0]), 32'd0);
      access(0, TOHOST, 32'h7, 4'hF, 1'b0, rd);
      chk("mbox_code", 32'(code[0]), 32'd3);
      chk("mbox_pass", 32'(pass[0]), 32'd0);
      access(0, TOHOST, 32'h0, 4'h0, 1'b0, rd);
      chk("mbox_read", rd, 32'h7);
      access(0, TOHOST, 32'h1, 4'hF, 1'b0, rd);
      check_state(0);

      // protocol abort: valid dropped while waiting
      do_reset(0);
      check_reset(0);
      @(posedge clk); #1;
      addr[0] = 32'hC; wdata[0] = ~m_mem[0][3]; wstrb[0] = 4'hF; valid[0] = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      valid[0] = 1'b0; wstrb[0] = 4'h0;
      repeat (8) @(posedge clk);
      m_err[0] = 1'b1; m_eaddr[0] = 32'hC;
      check_state(0);
      access(0, 32'hC, 32'h0, 4'h0, 1'b0, rd);
      check_state(0);

      // random-wait instance: 200 fetches
      for (int i = 0; i < 32; i++) access(1, 32'(i * 4), $urandom, 4'hF, 1'b0, rd);
      for (int i = 0; i < 200; i++)
         access(1, 32'($urandom_range(0, 31) * 4), 32'h0, 4'h0, 1'b1, rd);
      nseen = 0;
      for (int i = 0; i < 16; i++) if (seen_lat[i]) nseen++;
      chk("lat_variety", 32'(nseen >= 3), 32'd1);
      check_state(1);

      // reset in the middle of a write
      old_w10 = m_mem[1][10];
      @(posedge clk); #1;
      addr[1] = 32'h28; wdata[1] = ~old_w10; wstrb[1] = 4'hF; valid[1] = 1'b1;
      @(posedge clk); #1;
      rstn[1] = 1'b0; valid[1] = 1'b0; wstrb[1] = 4'h0;
      repeat (2) @(posedge clk);
      #1 rstn[1] = 1'b1;
      model_reset(1);
      check_reset(1);
      access(1, 32'h28, 32'h0, 4'h0, 1'b0, rd);
      chk("write_dropped", rd, old_w10);

      repeat (4) @(posedge clk);
      chk("q0_drained", 32'(exp_q0.size()), 32'd0);
      chk("q1_drained", 32'(exp_q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

endmodule
